regfile_writer: RTL

Write-side front end for the 16-entry register file. Accepts writeback requests from the datapath over a valid/ready handshake and buffers them in a small FIFO. Drains them one per cycle into the register file's single write port (regwrite / ra2 / wd), yielding that shared ra2 port whenever the datapath needs it for a read. An optional bypass lookup returns still-queued data for a register address, so readers see pending writes.

---
 rtl/regfile_writer_pkg.sv | 14 +
 rtl/regfile_writer_fifo.sv | 62 ++++++
 rtl/regfile_writer.sv | 92 +++++++++
 3 files changed

// File: rtl/regfile_writer_pkg.sv
// Shared constants and write-entry type for the register file write path.
package regfile_writer_pkg;

  localparam int RF_WIDTH   = 16;
  localparam int RF_REGBITS = 4;

  localparam logic [RF_REGBITS-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_REGBITS-1:0] addr;
    logic [RF_WIDTH-1:0]   data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_writer_fifo.sv
// Write-request queue: unreset storage with reset pointers and occupancy.
// Storage is exposed whole so the parent can search queued entries.
module regfile_writer_fifo
  import regfile_writer_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int REGBITS = RF_REGBITS,
  parameter int DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [REGBITS-1:0]               addr_i,
  input  logic [WIDTH-1:0]                 data_i,
  output logic [DEPTH-1:0][REGBITS-1:0]    mem_addr_o,
  output logic [DEPTH-1:0][WIDTH-1:0]      mem_data_o,
  output logic [$clog2(DEPTH)-1:0]         rd_ptr_o,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][REGBITS-1:0] mem_addr_q;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_data_q;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                 count_q, count_d;

  // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_addr_q[wr_ptr_q] <= addr_i;
      mem_data_q[wr_ptr_q] <= data_i;
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign count_o    = count_q;

endmodule

// File: rtl/regfile_writer.sv
// Write-side front end of the register file: queues writebacks and drains them
// into the shared ra2 write port. Bypass lookup built only with REGFILE_WRITER_BYPASS_EN.
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int REGBITS = RF_REGBITS,
  parameter int DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REGBITS-1:0]        in_addr,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      port_free,
  output logic                      rf_regwrite,
  output logic [REGBITS-1:0]        rf_waddr,
  output logic [WIDTH-1:0]          rf_wd,
  input  logic [REGBITS-1:0]        lk_addr,
  output logic                      lk_hit,
  output logic [WIDTH-1:0]          lk_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                          push;
  logic                          pop;
  logic [DEPTH-1:0][REGBITS-1:0] mem_addr;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_data;
  logic [PW-1:0]                 rd_ptr;

  // Handshake: a request transfers at a rising edge when in_valid && in_ready;
  // in_ready depends only on occupancy, so a full queue refuses even while popping.
  assign in_ready    = (count < CW'(DEPTH));
  assign push        = in_valid && in_ready && (in_addr != REGBITS'(REG_ZERO));
  assign rf_regwrite = (count != '0) && port_free;
  assign pop         = rf_regwrite;

  regfile_writer_fifo #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .addr_i     (in_addr),
    .data_i     (in_data),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_data),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count)
  );

  always_comb begin
    rf_waddr = '0;
    rf_wd    = '0;
    if (count != '0) begin
      rf_waddr = mem_addr[rd_ptr];
      rf_wd    = mem_data[rd_ptr];
    end
  end

`ifdef REGFILE_WRITER_BYPASS_EN
  logic [PW-1:0] lk_idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (mem_addr[lk_idx] == lk_addr) &&
          (lk_addr != REGBITS'(REG_ZERO))) begin
        lk_hit  = 1'b1;
        lk_data = mem_data[lk_idx];
      end
    end
  end
`else
  logic unused_lk_addr;
  assign unused_lk_addr = ^lk_addr;
  assign lk_hit         = 1'b0;
  assign lk_data        = '0;
`endif

endmodule
